// File: rtl/sev_seg_pkg.sv
// Shared constants for the seven-segment scan slice (nibble width, anode polarity).
package sev_seg_pkg;
  localparam int   NIB_W  = 4;
  localparam logic AN_OFF = 1'b1;
endpackage

// File: rtl/sev_seg_scan_if.sv
// Display-scan bus: value load strobe in, multiplexed digit/anode drive out.
interface sev_seg_scan_if #(parameter int NUM_DIGITS = 4);
  import sev_seg_pkg::*;

  logic [NIB_W*NUM_DIGITS-1:0] value_in;
  logic                        load;
  logic [NIB_W-1:0]            digit_nibble;
  logic [NUM_DIGITS-1:0]       an;
  logic                        busy;
  logic                        frame_done;

  modport master (output value_in, load,
                  input  digit_nibble, an, busy, frame_done);
  modport slave  (input  value_in, load,
                  output digit_nibble, an, busy, frame_done);
endinterface

// File: rtl/sev_seg_tick.sv
// Digit-slot prescaler: count runs 0..TICK_DIV-1, tick marks the last cycle of a slot.
module sev_seg_tick
  import sev_seg_pkg::*;
#(
  parameter int TICK_DIV = 100000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        tick,
  output logic [$clog2(TICK_DIV)-1:0] count
);
  localparam int              CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    count <= '0;
    else if (tick) count <= '0;
    else           count <= count + 1'b1;
  end
endmodule

// File: rtl/sev_seg_scan.sv
// Multiplexed hex display scanner with frame-synchronous value update.
// Define SEV_SEG_SCAN_LZB_EN to blank leading zero digits.
module sev_seg_scan
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 100000,
  parameter int DEAD_CYC   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  sev_seg_scan_if.slave  bus
);
  localparam int               CNT_W    = $clog2(TICK_DIV);
  localparam int               IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] DEAD_Q   = CNT_W'(DEAD_CYC);

  typedef logic [NUM_DIGITS-1:0][NIB_W-1:0] digits_t;

  logic                  tick, wrap, show;
  logic [CNT_W-1:0]      count, count_n;
  logic [IDX_W-1:0]      idx, idx_n;
  digits_t               disp, disp_n, pend;
  logic                  busy_q, fd_q;
  logic [NIB_W-1:0]      nib_q;
  logic [NUM_DIGITS-1:0] an_q, an_n;

  sev_seg_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .count (count)
  );

  assign wrap = tick && (idx == IDX_LAST);

  // Outputs are registered, so decode against the values the counters take next.
  assign count_n = tick ? '0 : count + 1'b1;
  assign idx_n   = !tick ? idx : (wrap ? '0 : idx + 1'b1);

  // Display only changes at the frame boundary; a load on that edge bypasses pending.
  always_comb begin
    disp_n = disp;
    if (wrap) begin
      if (bus.load)   disp_n = bus.value_in;
      else if (busy_q) disp_n = pend;
    end
  end

`ifdef SEV_SEG_SCAN_LZB_EN
  logic [IDX_W-1:0] msd;
  always_comb begin
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++)
      if (disp_n[i] != '0) msd = IDX_W'(i);
  end
  assign show = (idx_n <= msd);
`else
  assign show = 1'b1;
`endif

  assign an_n = (count_n < DEAD_Q || !show) ? {NUM_DIGITS{AN_OFF}}
                                            : ~(NUM_DIGITS'(1) << idx_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      disp   <= '0;
      pend   <= '0;
      busy_q <= 1'b0;
      fd_q   <= 1'b0;
      nib_q  <= '0;
      an_q   <= {NUM_DIGITS{AN_OFF}};
    end else begin
      idx  <= idx_n;
      disp <= disp_n;
      an_q <= an_n;
      fd_q <= wrap;
      if (tick) nib_q <= disp_n[idx_n];
      if (wrap) begin
        busy_q <= 1'b0;
      end else if (bus.load) begin
        pend   <= bus.value_in;
        busy_q <= 1'b1;
      end
    end
  end

  assign bus.digit_nibble = nib_q;
  assign bus.an           = an_q;
  assign bus.busy         = busy_q;
  assign bus.frame_done   = fd_q;
endmodule

// File: tb/tb_sev_seg_scan.sv
// Bench for sev_seg_scan (4 digits, 4-cycle slots, 1 dead cycle); honours SEV_SEG_SCAN_LZB_EN.
module tb_sev_seg_scan;
  localparam int ND = 4, TD = 4, DEAD = 1, FRAME = ND * TD;

  logic clk, rst_n;
  int   n_checks, n_fail;

  // reference state: edges since reset, shown value, pending value
  int          m_n;
  logic [15:0] m_disp, m_pend;
  logic        m_busy;

  sev_seg_scan_if #(.NUM_DIGITS(ND)) bus();

  sev_seg_scan #(.NUM_DIGITS(ND), .TICK_DIV(TD), .DEAD_CYC(DEAD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic        ld;
    logic [15:0] val;
    logic [3:0]  an;
    logic [3:0]  nib;
    logic        fd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, m_n, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_an(input int n, input logic [15:0] d);
    int   cnt, idx;
    logic en;
    cnt = n % TD;
    idx = (n / TD) % ND;
    en  = 1'b1;
`ifdef SEV_SEG_SCAN_LZB_EN
    begin
      int msd;
      msd = 0;
      for (int i = 1; i < ND; i++)
        if (((d >> (4 * i)) & 16'hF) != 0) msd = i;
      en = (idx <= msd);
    end
`endif
    if (cnt < DEAD || !en) return 4'hF;
    return ~(4'b0001 << idx);
  endfunction

  function automatic logic [3:0] exp_nib(input int n, input logic [15:0] d);
    int idx;
    idx = (n / TD) % ND;
    return 4'(d >> (4 * idx));
  endfunction

  // One clock: drive at negedge, update the reference at posedge, compare 1ns later.
  task automatic cyc(input logic ld, input logic [15:0] v);
    logic wrap;
    bus.load     = ld;
    bus.value_in = v;
    @(posedge clk);
    m_n++;
    wrap = (m_n % FRAME == 0);
    if (wrap) begin
      if (ld)          m_disp = v;
      else if (m_busy) m_disp = m_pend;
      m_busy = 1'b0;
    end else if (ld) begin
      m_pend = v;
      m_busy = 1'b1;
    end
    #1;
    check("an",         bus.an,           exp_an(m_n, m_disp));
    check("nibble",     bus.digit_nibble, exp_nib(m_n, m_disp));
    check("busy",       bus.busy,         m_busy);
    check("frame_done", bus.frame_done,   wrap);
    bus.load = 1'b0;
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_n = 0; m_disp = '0; m_pend = '0; m_busy = 1'b0;
  endtask

  task automatic run_to_wrap();
    while (m_n % FRAME != 0) cyc(1'b0, 16'h0);
  endtask

  vec_t        tbl[16];
  logic [3:0]  an_tab[16] = '{4'hE,4'hE,4'hE,4'hF, 4'hD,4'hD,4'hD,4'hF,
                              4'hB,4'hB,4'hB,4'hF, 4'h7,4'h7,4'h7,4'hF};
  logic [3:0]  exp30[4]   = '{4'hB, 4'hA, 4'h2, 4'h1};
  logic [15:0] rv;

  initial begin
    n_checks = 0; n_fail = 0;
    for (int k = 0; k < 16; k++) begin
      tbl[k] = '{1'b0, 16'h0, an_tab[k], 4'h0, (k == 15)};
`ifdef SEV_SEG_SCAN_LZB_EN
      if (tbl[k].an != 4'hE) tbl[k].an = 4'hF;
`endif
    end

    rst_n = 1'b0; bus.load = 1'b0; bus.value_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_an",   bus.an,           4'hF);
    check("rst_nib",  bus.digit_nibble, 4'h0);
    check("rst_busy", bus.busy,         1'b0);
    check("rst_fd",   bus.frame_done,   1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // idle frame after reset
    for (int k = 0; k < 16; k++) begin
      cyc(tbl[k].ld, tbl[k].val);
      check("tbl_an",  bus.an,           tbl[k].an);
      check("tbl_nib", bus.digit_nibble, tbl[k].nib);
      check("tbl_fd",  bus.frame_done,   tbl[k].fd);
    end

    // mid-frame load waits for the frame boundary
    repeat (5) cyc(1'b0, 16'h0);
    cyc(1'b1, 16'h12AB);
    check("busy_after_load", bus.busy, 1'b1);
    run_to_wrap();
    check("busy_after_wrap", bus.busy, 1'b0);
    for (int s = 0; s < 4; s++) begin
      check("frame_12ab", bus.digit_nibble, exp30[s]);
      repeat (4) cyc(1'b0, 16'h0);
    end

    // last load in a frame wins
    repeat (2) cyc(1'b0, 16'h0);
    cyc(1'b1, 16'h1111);
    cyc(1'b0, 16'h0);
    cyc(1'b1, 16'h2222);
    check("busy_overwrite", bus.busy, 1'b1);
    run_to_wrap();
    for (int s = 0; s < 4; s++) begin
      check("frame_2222", bus.digit_nibble, 4'h2);
      repeat (4) cyc(1'b0, 16'h0);
    end

    // load on the wrap edge bypasses pending
    while ((m_n + 1) % FRAME != 0) cyc(1'b0, 16'h0);
    cyc(1'b1, 16'hC0DE);
    check("bypass_nib",  bus.digit_nibble, 4'hE);
    check("bypass_busy", bus.busy,         1'b0);
    repeat (15) begin
      cyc(1'b0, 16'h0);
      check("bypass_busy_hold", bus.busy, 1'b0);
    end

`ifdef SEV_SEG_SCAN_LZB_EN
    cyc(1'b1, 16'h0050);
    run_to_wrap();
    for (int s = 0; s < 4; s++) begin
      cyc(1'b0, 16'h0);
      check("lzb_0050", bus.an, (s < 2) ? ~(4'b0001 << s) : 4'hF);
      repeat (3) cyc(1'b0, 16'h0);
    end
    cyc(1'b1, 16'h0000);
    run_to_wrap();
    for (int s = 0; s < 4; s++) begin
      cyc(1'b0, 16'h0);
      check("lzb_zero", bus.an, (s == 0) ? 4'hE : 4'hF);
      repeat (3) cyc(1'b0, 16'h0);
    end
`endif

    // asynchronous reset mid-slot while a value is pending
    repeat (6) cyc(1'b0, 16'h0);
    cyc(1'b1, 16'h5A5A);
    check("busy_before_rst", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_an",   bus.an,           4'hF);
    check("async_rst_busy", bus.busy,         1'b0);
    check("async_rst_nib",  bus.digit_nibble, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 2 * FRAME; k++) begin
      cyc(1'b0, 16'h0);
      check("post_rst_nib", bus.digit_nibble, 4'h0);
    end

    // randomized loads, including wrap-coincident and back-to-back ones
    repeat (500) begin
      rv = '0;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(1, 0) == 1) rv[4*i +: 4] = 4'($urandom_range(15, 0));
      cyc(($urandom_range(7, 0) == 0), rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sev_seg_scan.md
SEV_SEG_SCAN -- requirements
Module: sev_seg_scan

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (range 2..8).
REQ-002 SHALL have parameter TICK_DIV, default 100000, clock cycles per digit slot (minimum 4).
REQ-003 SHALL have parameter DEAD_CYC, default 2, cycles at slot start with all anodes off; must be less than TICK_DIV.
REQ-004 Port: clk  input  1  single system clock, rising-edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: value_in  input  4*NUM_DIGITS  hex value to show; digit 0 = bits [3:0], rightmost.
REQ-007 Port: load  input  1  one-cycle strobe capturing value_in.
REQ-008 Port: digit_nibble  output  4  nibble for the downstream 7-segment decoder.
REQ-009 Port: an  output  NUM_DIGITS  anode enables, active-low, at most one low.
REQ-010 Port: busy  output  1  high while a captured value awaits the frame boundary.
REQ-011 Port: frame_done  output  1  one-cycle pulse when digit index wraps to 0.

Function
REQ-012 Prescaler counts 0..TICK_DIV-1 and wraps; tick SHALL be asserted in the cycle count equals TICK_DIV-1.
REQ-013 Digit index SHALL advance by 1 on tick and wrap from NUM_DIGITS-1 to 0.
REQ-014 digit_nibble and an SHALL be registered, updated on the same edge as the digit index.
REQ-015 digit_nibble SHALL equal display[4*idx +: 4] of the new index.
REQ-016 an SHALL be all ones while prescaler count < DEAD_CYC, else only bit idx low.
REQ-017 load SHALL capture value_in into pending register and set busy on the next edge.
REQ-018 On index wrap to 0, display SHALL take pending if busy, then busy SHALL clear; no mid-frame tearing.
REQ-019 load coincident with wrap SHALL bypass: value_in goes straight to display, busy stays low.
REQ-020 load while busy SHALL overwrite pending (last value wins); busy stays high.
REQ-021 frame_done SHALL pulse high exactly one cycle, coincident with the edge index becomes 0.

Reset
REQ-022 rst_n low SHALL immediately force: prescaler 0, index 0, display 0, pending 0, busy 0, frame_done 0, digit_nibble 0, an all ones.
REQ-023 After reset release, first tick SHALL occur TICK_DIV cycles later; reset mid-frame discards pending data.

Configuration
REQ-024 Macro SEV_SEG_SCAN_LZB_EN SHALL enable leading-zero blanking.
REQ-025 With macro defined: digits above the most significant non-zero digit SHALL keep an high; digit 0 always shown; value 0 shows single "0".
REQ-026 Without macro: all NUM_DIGITS digits SHALL be driven per REQ-016.

Structure
REQ-027 Shared package sev_seg_pkg SHALL hold nibble width constant (4) and the active-low anode-off constant.
REQ-028 Prescaler SHALL be sub-module sev_seg_tick (parameter TICK_DIV, outputs tick and count); digit_nibble feeds sev_seg_dec externally, not instantiated here.

Verification (NUM_DIGITS=4, TICK_DIV=4, DEAD_CYC=1)
REQ-029 Reset then idle 16 cycles -> an sequence 1111,1110 / 1111,1101 / 1111,1011 / 1111,0111; digit_nibble 0; frame_done every 16 cycles.
REQ-030 load with value_in=16'h12AB mid-frame -> busy=1 until wrap; next frame digit_nibble B,A,2,1 for idx 0..3; busy=0.
REQ-031 load 16'h1111 then 16'h2222 in same frame -> next frame shows 2 on all digits only.
REQ-032 load 16'hC0DE coincident with wrap edge -> idx 0 shows E immediately, busy never asserts.
REQ-033 rst_n low mid-slot with busy=1 -> an=1111, busy=0 asynchronously; after release display 0.
REQ-034 With SEV_SEG_SCAN_LZB_EN, value 16'h0050 -> an low only for idx 0 and 1; value 0 -> only idx 0 enabled.
